// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: pays out a nickel count as quarter/dime/nickel pulses,
// one coin per acknowledgment, with a sticky jam fault on ack timeout.
module change_dispenser #(
  parameter int W       = 5,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [W-1:0] req_nickels,
  output logic         req_ready,
  output logic         Q,
  output logic         D,
  output logic         N,
  input  logic         coin_ack,
  output logic [W-1:0] remaining,
  output logic         busy,
  output logic         done,
  output logic         jam
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_JAM} state_t;
  typedef enum logic [1:0] {C_NICKEL, C_DIME, C_QUARTER} coin_t;

  state_t         state, state_n;
  coin_t          coin, coin_n;
  logic [W-1:0]   rem_n;
  logic [W-1:0]   rem_sub;
  logic [CW-1:0]  cnt, cnt_n;

  function automatic coin_t pick(input logic [W-1:0] amt);
    if (int'(amt) >= 5)      pick = C_QUARTER;
    else if (int'(amt) >= 2) pick = C_DIME;
    else                     pick = C_NICKEL;
  endfunction

  function automatic logic [W-1:0] coin_value(input coin_t c);
    case (c)
      C_QUARTER: coin_value = W'(5);
      C_DIME:    coin_value = W'(2);
      default:   coin_value = W'(1);
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      coin      <= C_NICKEL;
      remaining <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      coin      <= coin_n;
      remaining <= rem_n;
      cnt       <= cnt_n;
    end
  end

  // Coin type is chosen on the edge entering ISSUE so the pulses decode purely from registers.
  always_comb begin
    state_n = state;
    coin_n  = coin;
    rem_n   = remaining;
    cnt_n   = cnt;
    rem_sub = remaining - coin_value(coin);
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          rem_n   = req_nickels;
          coin_n  = pick(req_nickels);
          state_n = (req_nickels == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (coin_ack) begin
          rem_n   = rem_sub;
          coin_n  = pick(rem_sub);
          state_n = (rem_sub == '0) ? S_DONE : S_ISSUE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = S_JAM;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_JAM:   state_n = S_JAM;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    jam       = (state == S_JAM);
    Q         = (state == S_ISSUE) && (coin == C_QUARTER);
    D         = (state == S_ISSUE) && (coin == C_DIME);
    N         = (state == S_ISSUE) && (coin == C_NICKEL);
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: greedy coin model queued at request time,
// compared against each observed pulse, plus jam, reset and handshake scenarios.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [4:0] req_nickels;
  logic       req_ready;
  logic       Q, D, N;
  logic       coin_ack;
  logic [4:0] remaining;
  logic       busy, done, jam;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_coin[$];
  int exp_rem[$];

  change_dispenser #(.W(5), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_nickels(req_nickels),
    .req_ready(req_ready), .Q(Q), .D(D), .N(N), .coin_ack(coin_ack),
    .remaining(remaining), .busy(busy), .done(done), .jam(jam)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, want, $time);
    end
  endtask

  // dly: WAIT cycles before ack (0 = ack in first WAIT cycle); hold: amount kept on the bus while busy
  task automatic run_req(input int n, input int dly, input int hold);
    int r, v, wcnt, ncoins;
    bit fin;
    r = n;
    ncoins = 0;
    while (r > 0) begin
      v = (r >= 5) ? 5 : ((r >= 2) ? 2 : 1);
      exp_coin.push_back(v);
      exp_rem.push_back(r);
      r -= v;
      ncoins++;
    end
    @(negedge clk);
    check("ready_before", int'(req_ready), 1);
    req_valid   = 1'b1;
    req_nickels = 5'(n);
    @(negedge clk);
    if (hold != 0) req_nickels = 5'(hold);
    else req_valid = 1'b0;
    fin  = 1'b0;
    wcnt = 0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      coin_ack = 1'b0;
      if (Q | D | N) begin
        check("onehot", int'(Q) + int'(D) + int'(N), 1);
        if (exp_coin.size() == 0) begin
          check("extra_coin", 1, 0);
        end else begin
          v = exp_coin.pop_front();
          check("coin", Q ? 5 : (D ? 2 : 1), v);
          check("rem_at_issue", int'(remaining), exp_rem.pop_front());
        end
        wcnt = 0;
      end else if (done) begin
        check("done_cycle", cyc, ncoins * (2 + dly) + 1);
        check("coins_left", exp_coin.size(), 0);
        check("rem_done", int'(remaining), 0);
        check("jam_at_done", int'(jam), 0);
        req_valid = 1'b0;
        fin = 1'b1;
      end else if (busy) begin
        coin_ack = (wcnt == dly);
        wcnt++;
      end
      @(negedge clk);
    end
    coin_ack = 1'b0;
    if (!fin) check("timeout", 0, 1);
    check("ready_after", int'(req_ready), 1);
    check("rem_idle", int'(remaining), 0);
    exp_coin.delete();
    exp_rem.delete();
  endtask

  initial begin
    int wcnt;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_nickels = '0;
    coin_ack    = 1'b0;
    #12;
    check("rst_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_jam", int'(jam), 0);
    check("rst_done", int'(done), 0);
    check("rst_qdn", int'(Q | D | N), 0);
    check("rst_rem", int'(remaining), 0);
    @(negedge clk);
    reset = 1'b0;

    run_req(3, 0, 0);
    run_req(13, 0, 0);
    run_req(0, 0, 0);
    run_req(5, 15, 0);
    run_req(9, 1, 0);
    run_req(4, 0, 9);

    // stray ack in IDLE
    @(negedge clk);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    check("stray_ack_rem", int'(remaining), 0);
    check("stray_ack_busy", int'(busy), 0);

    // jam: 5 nickels, no ack ever
    req_valid   = 1'b1;
    req_nickels = 5'd5;
    @(negedge clk);
    req_valid = 1'b0;
    check("jam_q", int'(Q), 1);
    wcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (jam) break;
      check("jam_wait_qdn", int'(Q | D | N), 0);
      wcnt++;
    end
    check("jam_waits", wcnt, 16);
    check("jam_set", int'(jam), 1);
    check("jam_rem", int'(remaining), 5);
    check("jam_ready", int'(req_ready), 0);
    check("jam_busy", int'(busy), 1);
    req_valid   = 1'b1;
    req_nickels = 5'd3;
    coin_ack    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("jam_hold", int'(jam), 1);
      check("jam_hold_rem", int'(remaining), 5);
      check("jam_hold_qdn", int'(Q | D | N), 0);
    end
    req_valid = 1'b0;
    coin_ack  = 1'b0;
    reset     = 1'b1;
    #1;
    check("jam_clr", int'(jam), 0);
    check("jam_clr_ready", int'(req_ready), 1);
    check("jam_clr_rem", int'(remaining), 0);
    @(negedge clk);
    reset = 1'b0;

    // reset mid-WAIT of a 7-nickel request
    @(negedge clk);
    req_valid   = 1'b1;
    req_nickels = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_q", int'(Q), 1);
    @(negedge clk);
    check("mid_in_wait", int'(busy & ~(Q | D | N)), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_qdn", int'(Q | D | N), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    check("mid_jam", int'(jam), 0);
    check("mid_rem", int'(remaining), 0);
    check("mid_ready", int'(req_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    run_req(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
